// File: rtl/mem_port_router.sv
// Shared external memory port router: the owner channel (from sel) drives the port,
// and a tag FIFO steers each read response back to the channel that issued it.
module mem_port_router #(
    parameter int N_CH    = 4,
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int MAX_OUT = 8,
    parameter int SW      = $clog2(N_CH),
    parameter int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW-1:0]     sel,
    input  logic [N_CH-1:0]   c_wvalid,
    output logic [N_CH-1:0]   c_wready,
    input  logic [N_CH*AW-1:0] c_waddr,
    input  logic [N_CH*DW-1:0] c_wdata,
    input  logic [N_CH-1:0]   c_rvalid,
    output logic [N_CH-1:0]   c_rready,
    input  logic [N_CH*AW-1:0] c_raddr,
    output logic [N_CH-1:0]   c_rdvalid,
    output logic [N_CH*DW-1:0] c_rdata,
    output logic              wvalid,
    input  logic              wready,
    output logic [AW-1:0]     waddr,
    output logic [DW-1:0]     wdata,
    output logic              rvalid,
    input  logic              rready,
    output logic [AW-1:0]     raddr,
    input  logic              rdvalid,
    input  logic [DW-1:0]     rdata,
    output logic [SW-1:0]     owner,
    output logic [CW-1:0]     outstanding,
    output logic              switching,
    output logic              err_orphan
);
    localparam int PW = $clog2(MAX_OUT);

    logic [SW-1:0] owner_q, owner_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          err_orphan_q, err_orphan_d;
    logic [SW-1:0] tag_q [MAX_OUT];

    logic          live, full, push, pop, orphan;
    logic [SW-1:0] head_tag;

    // Handshakes are forced low while reset is held, even though inputs may be active.
    assign live      = ~rst;
    assign switching = (sel != owner_q);
    assign full      = (outstanding_q == CW'(MAX_OUT));
    assign head_tag  = tag_q[rptr_q];
    assign push      = rvalid & rready;
    assign pop       = rdvalid & live & (outstanding_q != '0);
    assign orphan    = rdvalid & live & (outstanding_q == '0);

    assign owner       = owner_q;
    assign outstanding = outstanding_q;
    assign err_orphan  = err_orphan_q;

    always_comb begin
        wvalid   = c_wvalid[owner_q] & ~switching & live;
        waddr    = c_waddr[owner_q*AW +: AW];
        wdata    = c_wdata[owner_q*DW +: DW];
        rvalid   = c_rvalid[owner_q] & ~switching & ~full & live;
        raddr    = c_raddr[owner_q*AW +: AW];
        c_wready = '0;
        c_rready = '0;
        c_wready[owner_q] = wready & ~switching & live;
        c_rready[owner_q] = rready & ~switching & ~full & live;
    end

    always_comb begin
        c_rdvalid = '0;
        c_rdata   = '0;
        if (pop) begin
            c_rdvalid[head_tag]         = 1'b1;
            c_rdata[head_tag*DW +: DW]  = rdata;
        end
    end

    always_comb begin
        owner_d      = sel;
        wptr_d       = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d       = pop  ? rptr_q + PW'(1) : rptr_q;
        err_orphan_d = err_orphan_q | orphan;
        case ({push, pop})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q       <= '0;
            outstanding_q <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            err_orphan_q  <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            outstanding_q <= outstanding_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

    // Tag storage is plain data; validity is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (push) tag_q[wptr_q] <= owner_q;
    end

endmodule

// File: tb/tb_mem_port_router.sv
// Bench for mem_port_router: directed scenarios plus a randomized run against a
// queue-based model of the routing and response-steering rules.
module tb_mem_port_router;
    localparam int N_CH = 4, AW = 26, DW = 32, MAX_OUT = 8, SW = 2, CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [SW-1:0] sel;
    logic [N_CH-1:0] c_wvalid, c_wready, c_rvalid, c_rready, c_rdvalid;
    logic [N_CH*AW-1:0] c_waddr, c_raddr;
    logic [N_CH*DW-1:0] c_wdata, c_rdata;
    logic wvalid, wready, rvalid, rready, rdvalid, switching, err_orphan;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] owner;
    logic [CW-1:0] outstanding;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_router #(.N_CH(N_CH), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .sel(sel),
        .c_wvalid(c_wvalid), .c_wready(c_wready), .c_waddr(c_waddr), .c_wdata(c_wdata),
        .c_rvalid(c_rvalid), .c_rready(c_rready), .c_raddr(c_raddr),
        .c_rdvalid(c_rdvalid), .c_rdata(c_rdata),
        .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
        .rvalid(rvalid), .rready(rready), .raddr(raddr),
        .rdvalid(rdvalid), .rdata(rdata),
        .owner(owner), .outstanding(outstanding), .switching(switching), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic settle(); @(negedge clk); endtask

    task automatic clear_inputs();
        c_wvalid = '0; c_rvalid = '0; c_waddr = '0; c_wdata = '0; c_raddr = '0;
        wready = 1'b0; rready = 1'b0; rdvalid = 1'b0; rdata = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = '0;
        c_wvalid = '1; c_rvalid = '1; c_waddr = '0; c_wdata = '0; c_raddr = '0;
        wready = 1'b1; rready = 1'b1; rdvalid = 1'b1; rdata = 32'h1234;
        settle();
        n_cmp++; if (wvalid !== 1'b0) begin n_bad++; $display("FAIL rst_wvalid: got %0h want 0", wvalid); end
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %0h want 0", rvalid); end
        n_cmp++; if (c_wready !== 4'b0) begin n_bad++; $display("FAIL rst_c_wready: got %b want 0000", c_wready); end
        n_cmp++; if (c_rready !== 4'b0) begin n_bad++; $display("FAIL rst_c_rready: got %b want 0000", c_rready); end
        n_cmp++; if (c_rdvalid !== 4'b0) begin n_bad++; $display("FAIL rst_c_rdvalid: got %b want 0000", c_rdvalid); end
        n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL rst_owner: got %0d want 0", owner); end
        n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL rst_err_orphan: got %0h want 0", err_orphan); end
        clear_inputs();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_write();
        sel = 2'd1;
        step();
        c_wvalid = 4'b1111; wready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            c_waddr[i*AW +: AW] = 26'h300 + 26'(i);
            c_wdata[i*DW +: DW] = 32'hC0DE0000 + 32'(i);
        end
        c_waddr[1*AW +: AW] = 26'h100;
        c_wdata[1*DW +: DW] = 32'hDEADBEEF;
        settle();
        n_cmp++; if (wvalid !== 1'b1) begin n_bad++; $display("FAIL wr_wvalid: got %0h want 1", wvalid); end
        n_cmp++; if (waddr !== 26'h100) begin n_bad++; $display("FAIL wr_waddr: got %0h want 100", waddr); end
        n_cmp++; if (wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_wdata: got %0h want deadbeef", wdata); end
        n_cmp++; if (c_wready !== 4'b0010) begin n_bad++; $display("FAIL wr_c_wready: got %b want 0010", c_wready); end
        step();
        clear_inputs();
    endtask

    task automatic test_read_steering();
        logic [N_CH*DW-1:0] exp_rd;
        int ch;
        rready = 1'b1;
        c_rvalid = 4'b0010;
        c_raddr[1*AW +: AW] = 26'h200;
        for (int k = 0; k < 3; k++) begin
            settle();
            n_cmp++; if (rvalid !== 1'b1 || raddr !== 26'h200) begin n_bad++; $display("FAIL rd_issue_ch1[%0d]: got rvalid=%0h raddr=%0h want 1/200", k, rvalid, raddr); end
            step();
        end
        c_rvalid = 4'b0100; sel = 2'd2;
        c_raddr[2*AW +: AW] = 26'h280;
        settle();
        n_cmp++; if (rvalid !== 1'b0 || switching !== 1'b1) begin n_bad++; $display("FAIL rd_bubble: got rvalid=%0h switching=%0h want 0/1", rvalid, switching); end
        step();
        for (int k = 0; k < 2; k++) begin
            settle();
            n_cmp++; if (rvalid !== 1'b1 || raddr !== 26'h280) begin n_bad++; $display("FAIL rd_issue_ch2[%0d]: got rvalid=%0h raddr=%0h want 1/280", k, rvalid, raddr); end
            step();
        end
        c_rvalid = '0;
        settle();
        n_cmp++; if (outstanding !== 4'd5) begin n_bad++; $display("FAIL rd_outstanding5: got %0d want 5", outstanding); end
        step();
        for (int k = 0; k < 5; k++) begin
            rdvalid = 1'b1; rdata = 32'hA0 + 32'(k);
            ch = (k < 3) ? 1 : 2;
            exp_rd = '0;
            exp_rd[ch*DW +: DW] = 32'hA0 + 32'(k);
            settle();
            n_cmp++; if (c_rdvalid !== 4'(1 << ch)) begin n_bad++; $display("FAIL rsp_rdvalid[%0d]: got %b want %b", k, c_rdvalid, 4'(1 << ch)); end
            n_cmp++; if (c_rdata !== exp_rd) begin n_bad++; $display("FAIL rsp_rdata[%0d]: got %h want %h", k, c_rdata, exp_rd); end
            step();
        end
        rdvalid = 1'b0;
        settle();
        n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("FAIL rd_outstanding0: got %0d want 0", outstanding); end
        step();
        clear_inputs();
    endtask

    task automatic test_switch_bubble();
        sel = 2'd1;
        step();
        sel = 2'd2; c_wvalid = 4'b0100; wready = 1'b1;
        c_waddr[2*AW +: AW] = 26'h3A5; c_wdata[2*DW +: DW] = 32'h12345678;
        settle();
        n_cmp++; if (switching !== 1'b1 || wvalid !== 1'b0 || c_wready !== 4'b0) begin n_bad++; $display("FAIL sw_bubble: got switching=%0h wvalid=%0h c_wready=%b want 1/0/0000", switching, wvalid, c_wready); end
        n_cmp++; if (owner !== 2'd1) begin n_bad++; $display("FAIL sw_owner_old: got %0d want 1", owner); end
        step();
        settle();
        n_cmp++; if (switching !== 1'b0 || wvalid !== 1'b1 || c_wready !== 4'b0100) begin n_bad++; $display("FAIL sw_after: got switching=%0h wvalid=%0h c_wready=%b want 0/1/0100", switching, wvalid, c_wready); end
        n_cmp++; if (owner !== 2'd2 || waddr !== 26'h3A5 || wdata !== 32'h12345678) begin n_bad++; $display("FAIL sw_fwd: got owner=%0d waddr=%0h wdata=%0h want 2/3a5/12345678", owner, waddr, wdata); end
        step();
        clear_inputs();
    endtask

    task automatic test_full_fifo();
        c_rvalid = 4'b0100; rready = 1'b1;
        for (int k = 0; k < MAX_OUT; k++) step();
        settle();
        n_cmp++; if (outstanding !== 4'd8) begin n_bad++; $display("FAIL full_count: got %0d want 8", outstanding); end
        n_cmp++; if (rvalid !== 1'b0 || c_rready !== 4'b0) begin n_bad++; $display("FAIL full_block: got rvalid=%0h c_rready=%b want 0/0000", rvalid, c_rready); end
        step();
        rdvalid = 1'b1; rdata = 32'h77;
        settle();
        n_cmp++; if (rvalid !== 1'b0 || c_rdvalid !== 4'b0100) begin n_bad++; $display("FAIL full_pop_cycle: got rvalid=%0h c_rdvalid=%b want 0/0100", rvalid, c_rdvalid); end
        step();
        rdvalid = 1'b0;
        settle();
        n_cmp++; if (outstanding !== 4'd7 || rvalid !== 1'b1) begin n_bad++; $display("FAIL full_after_pop: got outstanding=%0d rvalid=%0h want 7/1", outstanding, rvalid); end
        step();
        settle();
        n_cmp++; if (outstanding !== 4'd8) begin n_bad++; $display("FAIL full_refill: got %0d want 8", outstanding); end
        step();
        c_rvalid = '0; rdvalid = 1'b1;
        for (int k = 0; k < MAX_OUT; k++) step();
        rdvalid = 1'b0;
        settle();
        n_cmp++; if (outstanding !== 4'd0 || err_orphan !== 1'b0) begin n_bad++; $display("FAIL full_drain: got outstanding=%0d err_orphan=%0h want 0/0", outstanding, err_orphan); end
        step();
        clear_inputs();
    endtask

    task automatic test_orphan();
        sel = 2'd0;
        pulse_reset();
        rdvalid = 1'b1; rdata = 32'h55;
        settle();
        n_cmp++; if (c_rdvalid !== 4'b0 || c_rdata !== '0) begin n_bad++; $display("FAIL orph_drop: got c_rdvalid=%b c_rdata=%h want 0", c_rdvalid, c_rdata); end
        step();
        rdvalid = 1'b0;
        settle();
        n_cmp++; if (err_orphan !== 1'b1 || outstanding !== 4'd0) begin n_bad++; $display("FAIL orph_flag: got err_orphan=%0h outstanding=%0d want 1/0", err_orphan, outstanding); end
        step(); step();
        settle();
        n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL orph_sticky: got %0h want 1", err_orphan); end
        step();
    endtask

    task automatic test_reset_mid();
        sel = 2'd3;
        step();
        c_rvalid = 4'b1000; rready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        c_rvalid = '0;
        settle();
        n_cmp++; if (outstanding !== 4'd4) begin n_bad++; $display("FAIL mid_count: got %0d want 4", outstanding); end
        step();
        c_rvalid = 4'b1000;
        rst = 1'b1;
        settle();
        n_cmp++; if (outstanding !== 4'd0 || owner !== 2'd0 || err_orphan !== 1'b0) begin n_bad++; $display("FAIL mid_reset: got outstanding=%0d owner=%0d err_orphan=%0h want 0/0/0", outstanding, owner, err_orphan); end
        n_cmp++; if (rvalid !== 1'b0 || c_rready !== 4'b0) begin n_bad++; $display("FAIL mid_reset_hs: got rvalid=%0h c_rready=%b want 0/0000", rvalid, c_rready); end
        step();
        rst = 1'b0; c_rvalid = '0; sel = 2'd0;
        step();
        rdvalid = 1'b1; rdata = 32'h99;
        settle();
        n_cmp++; if (c_rdvalid !== 4'b0) begin n_bad++; $display("FAIL mid_stale_drop: got %b want 0000", c_rdvalid); end
        step();
        rdvalid = 1'b0;
        settle();
        n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL mid_stale_flag: got %0h want 1", err_orphan); end
        step();
        clear_inputs();
    endtask

    task automatic test_random();
        int own_m, tq[$];
        logic err_m, sw, full_m, e_wvalid, e_rvalid;
        logic [N_CH-1:0] e_cwr, e_crr, e_rdv;
        logic [N_CH*DW-1:0] e_rdata;
        sel = 2'd0;
        pulse_reset();
        own_m = 0; err_m = 1'b0; tq.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
            c_wvalid = 4'($urandom); c_rvalid = 4'($urandom);
            for (int i = 0; i < N_CH; i++) begin
                c_waddr[i*AW +: AW] = 26'($urandom);
                c_wdata[i*DW +: DW] = $urandom;
                c_raddr[i*AW +: AW] = 26'($urandom);
            end
            wready = ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
            rdvalid = (cyc < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            rdata = $urandom;
            settle();
            sw = (int'(sel) != own_m);
            full_m = (tq.size() == MAX_OUT);
            e_wvalid = c_wvalid[own_m] && !sw;
            e_rvalid = c_rvalid[own_m] && !sw && !full_m;
            e_cwr = (wready && !sw) ? 4'(1 << own_m) : 4'b0;
            e_crr = (rready && !sw && !full_m) ? 4'(1 << own_m) : 4'b0;
            e_rdv = '0; e_rdata = '0;
            if (rdvalid && tq.size() > 0) begin
                e_rdv = 4'(1 << tq[0]);
                e_rdata[tq[0]*DW +: DW] = rdata;
            end
            n_cmp++; if (switching !== sw) begin n_bad++; $display("FAIL rnd_switching @%0d: got %0h want %0h", cyc, switching, sw); end
            n_cmp++; if (owner !== 2'(own_m)) begin n_bad++; $display("FAIL rnd_owner @%0d: got %0d want %0d", cyc, owner, own_m); end
            n_cmp++; if (outstanding !== 4'(tq.size())) begin n_bad++; $display("FAIL rnd_outstanding @%0d: got %0d want %0d", cyc, outstanding, tq.size()); end
            n_cmp++; if (err_orphan !== err_m) begin n_bad++; $display("FAIL rnd_err_orphan @%0d: got %0h want %0h", cyc, err_orphan, err_m); end
            n_cmp++; if (wvalid !== e_wvalid) begin n_bad++; $display("FAIL rnd_wvalid @%0d: got %0h want %0h", cyc, wvalid, e_wvalid); end
            n_cmp++; if (waddr !== c_waddr[own_m*AW +: AW] || wdata !== c_wdata[own_m*DW +: DW]) begin n_bad++; $display("FAIL rnd_wfields @%0d: got %0h/%0h want %0h/%0h", cyc, waddr, wdata, c_waddr[own_m*AW +: AW], c_wdata[own_m*DW +: DW]); end
            n_cmp++; if (c_wready !== e_cwr) begin n_bad++; $display("FAIL rnd_c_wready @%0d: got %b want %b", cyc, c_wready, e_cwr); end
            n_cmp++; if (rvalid !== e_rvalid) begin n_bad++; $display("FAIL rnd_rvalid @%0d: got %0h want %0h", cyc, rvalid, e_rvalid); end
            n_cmp++; if (raddr !== c_raddr[own_m*AW +: AW]) begin n_bad++; $display("FAIL rnd_raddr @%0d: got %0h want %0h", cyc, raddr, c_raddr[own_m*AW +: AW]); end
            n_cmp++; if (c_rready !== e_crr) begin n_bad++; $display("FAIL rnd_c_rready @%0d: got %b want %b", cyc, c_rready, e_crr); end
            n_cmp++; if (c_rdvalid !== e_rdv) begin n_bad++; $display("FAIL rnd_c_rdvalid @%0d: got %b want %b", cyc, c_rdvalid, e_rdv); end
            n_cmp++; if (c_rdata !== e_rdata) begin n_bad++; $display("FAIL rnd_c_rdata @%0d: got %h want %h", cyc, c_rdata, e_rdata); end
            if (rdvalid) begin
                if (tq.size() > 0) void'(tq.pop_front());
                else err_m = 1'b1;
            end
            if (e_rvalid && rready) tq.push_back(own_m);
            own_m = int'(sel);
            step();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_write();
        test_read_steering();
        test_switch_bubble();
        test_full_fifo();
        test_orphan();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
